mem_fifo: RTL and testbench
===========================

# mem_fifo

Synchronous single-clock FIFO storage used as the buffer behind a write/read request–acknowledge bridge. Write enable and read enable are both sampled at the same clock edge, so the bridge can drive them combinationally from its next-state logic. Full and empty status flags let the bridge stall writes or reads. Data leaves in first-in, first-out order through a registered read port.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 3, width of the read and write pointers.
- RAM_DEPTH, 1 << ADDR_WIDTH, number of storage words; must be ≥ 2 and ≤ 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high; clock clk.
- REnable_i  in  1  read request; pops one word at the edge if not empty.
- WEnable_i  in  1  write request; pushes Data_i at the edge if not full.
- Data_i  in  DATA_WIDTH  write data, sampled with WEnable_i.
- Data_o  out  DATA_WIDTH  registered read data.
- Empty_o  out  1  high when count == 0.
- Full_o  out  1  high when count == RAM_DEPTH.

## Operation
- State: storage array of RAM_DEPTH × DATA_WIDTH, write pointer wr_ptr, read pointer rd_ptr (each ADDR_WIDTH bits), and an occupancy count (ADDR_WIDTH+1 bits).
- Write accept = WEnable_i & ~Full_o:
  - mem[wr_ptr] <= Data_i.
  - wr_ptr advances; it wraps from RAM_DEPTH-1 to 0.
- Read accept = REnable_i & ~Empty_o:
  - Data_o <= mem[rd_ptr].
  - rd_ptr advances with the same wrap rule.
- Count update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on both or neither.
- Empty_o and Full_o are combinational decodes of the registered count. They are therefore evaluated on pre-edge state.
- Write while full is dropped silently: storage, pointers and count are unchanged.
- Read while empty is dropped silently: Data_o holds its previous value.
- Simultaneous read and write:
  - Neither full nor empty: both are accepted and the count is unchanged.
  - Full: the read is accepted and the write is dropped, so the count becomes RAM_DEPTH-1.
  - Empty: the write is accepted and the read is dropped, so the count becomes 1 and Data_o holds. There is no write-to-read bypass.
- Data_o holds its value whenever no read is accepted.
- No error outputs. Overflow and underflow are the caller's responsibility, enforced via the flags.

## Timing
- Reset, synchronous and overriding all other activity in that cycle:
  - wr_ptr=0, rd_ptr=0, count=0.
  - Data_o=0, Empty_o=1, Full_o=0.
  - Storage contents are untouched unless the Configuration macro says otherwise.
- Reset asserted mid-operation discards all queued words, including any write or read presented in the same cycle.
- Write latency:
  - A word written at edge N is readable by a read accepted at edge N+1 or later.
  - Empty_o falls immediately after edge N.
- Read latency: Data_o shows the popped word immediately after the accepting edge, i.e. one cycle after REnable_i is sampled.
- Flags update after the edge that changes the count. Full_o rises after the RAM_DEPTH-th outstanding write.

## Configuration
- MEM_FIFO_CLEAR_ON_RESET_EN defined: reset additionally writes 0 to every storage word, which makes contents deterministic.
- Not defined: storage has no reset and its contents are don't-care until written.
- Flags and data ordering are identical in both builds.

## Test plan
- Reset asserted 2 cycles -> Empty_o=1, Full_o=0, Data_o=0x00. WEnable_i/REnable_i held high during reset have no effect.
- Write 0xA5 for one cycle, then read one cycle -> Empty_o=0 after the write edge; Data_o=0xA5 and Empty_o=1 after the read edge.
- Write 0x10..0x17 (8 cycles), then write 0xFF -> Full_o=1 after the 8th write; 0xFF is dropped. Eight reads return 0x10..0x17 in order, then Empty_o=1.
- Read on empty after the last read -> Data_o holds 0x17, flags unchanged.
- With 3 words queued, hold read and write together for 10 cycles (data 0x20..0x29) -> count stays 3 and pointers wrap past 7. Draining afterwards yields 0x27, 0x28, 0x29.
- Fill to full, then read and write together -> the read returns the oldest word, the write is dropped, and Full_o=0 afterwards.

Source files
------------

// File: rtl/mem_fifo.sv
// Single-clock FIFO with registered read port and count-decoded flags.
// MEM_FIFO_CLEAR_ON_RESET_EN: reset also zeroes every storage word.
module mem_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  REnable_i,
  input  logic                  WEnable_i,
  input  logic [DATA_WIDTH-1:0] Data_i,
  output logic [DATA_WIDTH-1:0] Data_o,
  output logic                  Empty_o,
  output logic                  Full_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH =
    (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(RAM_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_acc;
  logic                  rd_acc;

  assign Empty_o = (count == '0);
  assign Full_o  = (count == DEPTH);
  assign wr_acc  = WEnable_i & ~Full_o;
  assign rd_acc  = REnable_i & ~Empty_o;

  // Storage kept apart from control state so it can map to RAM.
  always_ff @(posedge clk) begin
`ifdef MEM_FIFO_CLEAR_ON_RESET_EN
    if (reset) begin
      for (int i = 0; i < RAM_DEPTH; i++)
        mem[i] <= '0;
    end else
`endif
    if (wr_acc)
      mem[wr_ptr] <= Data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      Data_o <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
        Data_o <= mem[rd_ptr];
      end
      if (wr_acc && !rd_acc)
        count <= count + 1'b1;
      else if (rd_acc && !wr_acc)
        count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_fifo.sv
// Self-checking bench for mem_fifo: vector table, corner sequences
// and random traffic against a queue-based reference model.
module tb_mem_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       REnable_i = 1'b0;
  logic       WEnable_i = 1'b0;
  logic [7:0] Data_i = '0;
  logic [7:0] Data_o;
  logic       Empty_o;
  logic       Full_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] q [$];
  logic [7:0] m_dout = '0;

  typedef struct {
    logic       rst;
    logic       ren;
    logic       wen;
    logic [7:0] din;
    logic [7:0] dout;
    logic       empty;
    logic       full;
  } vec_t;

  vec_t vecs [$];

  mem_fifo #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .REnable_i(REnable_i),
    .WEnable_i(WEnable_i),
    .Data_i   (Data_i),
    .Data_o   (Data_o),
    .Empty_o  (Empty_o),
    .Full_o   (Full_o)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, r, w,
                     input logic [7:0] d, o,
                     input logic e, f);
    vec_t v;
    v.rst = rst; v.ren = r; v.wen = w; v.din = d;
    v.dout = o; v.empty = e; v.full = f;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm,
                     input logic [7:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: FIFO rules applied to a queue, decisions on pre-edge size.
  task automatic step(input logic rst, r, w,
                      input logic [7:0] d);
    bit pop_ok, push_ok;
    reset = rst; REnable_i = r; WEnable_i = w; Data_i = d;
    if (rst) begin
      q.delete();
      m_dout = '0;
    end else begin
      pop_ok  = r && (q.size() > 0);
      push_ok = w && (q.size() < DEPTH);
      if (pop_ok)  m_dout = q.pop_front();
      if (push_ok) q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".dout"}, Data_o, m_dout);
    chk({nm, ".empty"}, {7'd0, Empty_o}, {7'd0, q.size() == 0});
    chk({nm, ".full"}, {7'd0, Full_o}, {7'd0, q.size() == DEPTH});
  endtask

  initial begin
    add(1, 1, 1, 8'h55, 8'h00, 1, 0);
    add(1, 1, 1, 8'h55, 8'h00, 1, 0);
    add(0, 0, 1, 8'hA5, 8'h00, 0, 0);
    add(0, 1, 0, 8'h00, 8'hA5, 1, 0);
    for (int i = 0; i < 8; i++)
      add(0, 0, 1, 8'(8'h10 + i), 8'hA5, 0, i == 7);
    add(0, 0, 1, 8'hFF, 8'hA5, 0, 1);
    for (int i = 0; i < 8; i++)
      add(0, 1, 0, 8'h00, 8'(8'h10 + i), i == 7, 0);
    add(0, 1, 0, 8'h00, 8'h17, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].ren, vecs[i].wen, vecs[i].din);
      chk($sformatf("vec%0d.dout", i), Data_o, vecs[i].dout);
      chk($sformatf("vec%0d.empty", i),
          {7'd0, Empty_o}, {7'd0, vecs[i].empty});
      chk($sformatf("vec%0d.full", i),
          {7'd0, Full_o}, {7'd0, vecs[i].full});
    end

    // Three queued, ten simultaneous read+write cycles wrap pointers.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'(8'h01 + i));
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 8'(8'h20 + i));
      chk_model("rw_hold");
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 8'h00);
      chk("drain", Data_o, 8'(8'h27 + i));
    end
    chk("drain.empty", {7'd0, Empty_o}, 8'd1);

    // Full with read+write: read wins, write dropped.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'(8'h40 + i));
    chk("fill.full", {7'd0, Full_o}, 8'd1);
    step(0, 1, 1, 8'h99);
    chk("full_rw.dout", Data_o, 8'h40);
    chk("full_rw.full", {7'd0, Full_o}, 8'd0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 8'h00);
    chk("full_rw.last", Data_o, 8'h47);
    chk("full_rw.empty", {7'd0, Empty_o}, 8'd1);

    // Empty with read+write: write accepted, Data_o holds.
    step(0, 1, 1, 8'h66);
    chk("empty_rw.dout", Data_o, 8'h47);
    chk("empty_rw.empty", {7'd0, Empty_o}, 8'd0);
    step(0, 1, 0, 8'h00);
    chk("empty_rw.pop", Data_o, 8'h66);

    // Reset mid-operation discards queued words.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(8'h70 + i));
    step(1, 1, 1, 8'h33);
    chk_model("mid_reset");

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0),
           ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 99) < 55),
           8'($urandom));
      chk_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
